// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared widths and index types for the 256-bit priority encoder
package pe_pkg;
   localparam int LANE_W    = 64;
   localparam int NUM_LANES = 4;
   localparam int Q_W       = 8;

   typedef logic [5:0] lane_idx_t;
   typedef logic [7:0] pe_idx_t;
endpackage

// File: rtl/pe64.sv
// rtl/pe64.sv - combinational 64-bit highest-index-wins priority encoder lane
module pe64
   import pe_pkg::*;
(
   input  logic [LANE_W-1:0] d,
   output lane_idx_t         q,
   output logic              v
);

   // Ascending scan so the last hit, i.e. the highest set bit, wins.
   always_comb begin
      q = '0;
      v = |d;
      for (int i = 0; i < LANE_W; i++) begin
         if (d[i]) q = i[5:0];
      end
   end

endmodule

// File: rtl/pe256_from_pe64.sv
// rtl/pe256_from_pe64.sv - registered 256-bit priority encoder from four pe64 lanes
// Optional input register: define PE256_INPUT_REG_EN (latency 2 instead of 1).
module pe256_from_pe64
   import pe_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [LANE_W*NUM_LANES-1:0] d,
   output logic [Q_W-1:0]              q,
   output logic                        v
);

   logic [LANE_W*NUM_LANES-1:0] d_enc;
   lane_idx_t                   lane_q [NUM_LANES];
   logic [NUM_LANES-1:0]        lane_v;
   pe_idx_t                     sel_q;
   logic                        sel_v;

`ifdef PE256_INPUT_REG_EN
   logic [LANE_W*NUM_LANES-1:0] d_reg;

   always_ff @(posedge clk) begin
      if (rst) d_reg <= '0;
      else     d_reg <= d;
   end

   assign d_enc = d_reg;
`else
   assign d_enc = d;
`endif

   generate
      for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
         pe64 u_pe64 (
            .d (d_enc[k*LANE_W +: LANE_W]),
            .q (lane_q[k]),
            .v (lane_v[k])
         );
      end
   endgenerate

   // Upper lanes override lower ones; idle lanes drive q=0 so nothing undefined leaks through.
   always_comb begin
      sel_q = '0;
      sel_v = |lane_v;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (lane_v[k]) sel_q = {k[1:0], lane_q[k]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
         v <= 1'b0;
      end else begin
         q <= sel_q;
         v <= sel_v;
      end
   end

endmodule

// File: tb/tb_pe256_from_pe64.sv
// tb/tb_pe256_from_pe64.sv - randomized and directed self-checking bench for pe256_from_pe64
module tb_pe256_from_pe64;

`ifdef PE256_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      logic [7:0] q;
      logic       v;
      string      tag;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] d;
   logic [7:0]   q;
   logic         v;

   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t exp_q[$];

   pe256_from_pe64 dut (
      .clk (clk),
      .rst (rst),
      .d   (d),
      .q   (q),
      .v   (v)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] ref_pe(input logic [255:0] x);
      for (int i = 255; i >= 0; i--) begin
         if (x[i]) return {1'b1, i[7:0]};
      end
      return 9'd0;
   endfunction

   task automatic check(input string tag, input logic [7:0] eq, input logic ev);
      n_cmp++;
      assert (q === eq && v === ev)
      else begin
         n_fail++;
         $error("FAIL %s: got q=%0d v=%b, expected q=%0d v=%b", tag, q, v, eq, ev);
      end
   endtask

   // Drive one vector per cycle; each result is checked exactly LAT cycles after it was applied.
   task automatic step(input logic [255:0] val, input string tag);
      exp_t       e;
      logic [8:0] r;
      r     = ref_pe(val);
      e.q   = r[7:0];
      e.v   = r[8];
      e.tag = tag;
      d     = val;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() >= LAT) begin
         e = exp_q.pop_front();
         check(e.tag, e.q, e.v);
      end
   endtask

   task automatic hold_reset(input int cycles, input string tag);
      rst = 1'b1;
      exp_q.delete();
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         check(tag, 8'd0, 1'b0);
      end
      rst = 1'b0;
   endtask

   initial begin
      logic [255:0] val;
      logic [255:0] one;

      one = 256'd1;
      rst = 1'b1;
      d   = '1;

      hold_reset(2, "reset_all_ones");
      step('1, "release_all_ones");
      step('1, "all_ones_hold");

      step('0, "zero");
      step('0, "zero_again");

      for (int i = 0; i < 256; i++) begin
         step(one << i, $sformatf("onehot_%0d", i));
      end

      val = '0; val[5] = 1'b1; val[123] = 1'b1; val[200] = 1'b1;
      step(val, "bits_5_123_200");
      step('1, "all_ones");
      val = '0; val[0] = 1'b1; val[63] = 1'b1; val[64] = 1'b1;
      step(val, "bits_0_63_64");
      val = '0; val[0] = 1'b1;
      step(val, "bit0_only");

      step(one << 10, "b2b_10");
      step(one << 70, "b2b_70");
      step('0, "b2b_zero");
      step(one << 255, "b2b_255");

      // Reset with results still in flight must discard them.
      step(one << 99, "pre_midreset");
      d = one << 150;
      hold_reset(2, "midstream_reset");

      for (int n = 0; n < 1000; n++) begin
         for (int w = 0; w < 8; w++) begin
            val[w*32 +: 32] = ($urandom_range(0, 1) == 1) ? $urandom() : 32'd0;
         end
         if ($urandom_range(0, 3) == 0) val[255:128] = '0;
         step(val, $sformatf("random_%0d", n));
      end

      for (int f = 1; f < LAT; f++) begin
         step('0, "flush");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
